// File: rtl/snn_step_scheduler_if.sv
// rtl/snn_step_scheduler_if.sv - presynaptic spike input channel bundle
//
// Purpose: groups the N_IN spike input channels of snn_step_scheduler.
// Signals:
//   in_valid  [N_IN]     per-channel spike valid (source -> scheduler)
//   in_index  [N_IN*SW]  per-channel presynaptic index, channel k at [k*SW +: SW]
//   in_ready  [N_IN]     per-channel accept (scheduler -> source)
// Modports: master = spike source, slave = scheduler.
interface snn_step_scheduler_if #(
  parameter int N_IN = 4,
  parameter int SW   = 14
);
  logic [N_IN-1:0]    in_valid;
  logic [N_IN*SW-1:0] in_index;
  logic [N_IN-1:0]    in_ready;

  modport master (output in_valid, output in_index, input in_ready);
  modport slave  (input in_valid, input in_index, output in_ready);
endinterface

// File: rtl/snn_step_scheduler.sv
// rtl/snn_step_scheduler.sv - time-multiplexed SNN step scheduler with spike FIFO
//
// Purpose: sequences neuron-SRAM read/write sweeps, one PROC sweep per step
// followed by one ACCU sweep per queued spike, for a programmed number of
// steps or free-running until stop. Spikes from N_IN channels are round-robin
// arbitrated into a FIFO in every state.
// Ports:
//   clk, reset        clock / asynchronous active-high reset
//   start, stop       run control (start sampled in IDLE, stop sticky while busy)
//   num_steps         steps to run, 0 = free-run
//   spk               spike input channels (slave modport)
//   c_neuron_index    neuron SRAM address (sweep index)
//   c_synapse_index   synapse row of the spike being accumulated
//   c_neuron_we       neuron SRAM write enable (write phase)
//   c_accumulate      1 = accumulator sweep, 0 = updater sweep
//   network_time      completed steps
//   fifo_level        spike FIFO occupancy
//   busy, done        run status / 1-cycle pulse on return to IDLE
module snn_step_scheduler #(
  parameter int NR_DEPTH         = 16,
  parameter int SR_DEPTH         = 16384,
  parameter int N_IN             = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int MAX_NETWORK_TIME = 65536,
  localparam int NW = $clog2(NR_DEPTH),
  localparam int SW = $clog2(SR_DEPTH),
  localparam int TW = $clog2(MAX_NETWORK_TIME),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [TW-1:0]          num_steps,
  snn_step_scheduler_if.slave    spk,
  output logic [NW-1:0]          c_neuron_index,
  output logic [SW-1:0]          c_synapse_index,
  output logic                   c_neuron_we,
  output logic                   c_accumulate,
  output logic [TW-1:0]          network_time,
  output logic [LW-1:0]          fifo_level,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_ACCU} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [SW-1:0] syn_q, syn_d;
  logic [TW-1:0] time_q, time_d;
  logic [TW-1:0] steps_q, steps_d;
  logic          stop_flag_q, stop_flag_d;
  logic          done_q, done_d;
  logic [RW-1:0] rr_q, rr_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] count_q, count_d;
  logic [SW-1:0] mem_q [FIFO_DEPTH];

  logic          full, empty, push, pop, sweep_last;
  logic [RW-1:0] grant_idx;
  logic [SW-1:0] push_data;
  logic [TW-1:0] time_inc;

  assign full  = (count_q == LW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Round-robin arbiter: first valid channel at/after rr_q wins. Readiness
  // looks only at full, so a same-cycle pop never opens a slot early.
  always_comb begin
    push      = 1'b0;
    grant_idx = '0;
    if (!full) begin
      for (int off = 0; off < N_IN; off++) begin
        if (!push && spk.in_valid[(int'(rr_q) + off) % N_IN]) begin
          push      = 1'b1;
          grant_idx = RW'((int'(rr_q) + off) % N_IN);
        end
      end
    end
  end

  assign spk.in_ready = push ? (N_IN'(1) << grant_idx) : '0;
  assign push_data    = spk.in_index[int'(grant_idx)*SW +: SW];

  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (int'(grant_idx) == N_IN - 1) ? '0 : grant_idx + RW'(1);
  end

  assign sweep_last = phase_q && (idx_q == NW'(NR_DEPTH - 1));
  assign time_inc   = (time_q == TW'(MAX_NETWORK_TIME - 1)) ? '0 : time_q + TW'(1);

  // Sequencer. STEP_END is folded into the last write cycle of a sweep so
  // back-to-back steps run without a gap.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    syn_d       = syn_q;
    time_d      = time_q;
    steps_d     = steps_q;
    stop_flag_d = stop_flag_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PROC;
          idx_d       = '0;
          phase_d     = 1'b0;
          steps_d     = num_steps;
          stop_flag_d = 1'b0;
        end
      end
      default: begin
        if (stop) stop_flag_d = 1'b1;
        if (!sweep_last) begin
          phase_d = !phase_q;
          if (phase_q) idx_d = idx_q + NW'(1);
        end else begin
          idx_d   = '0;
          phase_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            syn_d   = mem_q[rd_q];
            state_d = S_ACCU;
          end else begin
            time_d  = time_inc;
            state_d = S_PROC;
            // A stop arriving on the final cycle still ends this step.
            if (stop_flag_q || stop || (steps_q != '0 && time_inc == steps_q)) begin
              state_d     = S_IDLE;
              done_d      = 1'b1;
              stop_flag_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop  ? rd_q + AW'(1) : rd_q;
    count_d = count_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      syn_q       <= '0;
      time_q      <= '0;
      steps_q     <= '0;
      stop_flag_q <= 1'b0;
      done_q      <= 1'b0;
      rr_q        <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      syn_q       <= syn_d;
      time_q      <= time_d;
      steps_q     <= steps_d;
      stop_flag_q <= stop_flag_d;
      done_q      <= done_d;
      rr_q        <= rr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      if (push) mem_q[wr_q] <= push_data;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign c_neuron_index  = idx_q;
  assign c_neuron_we     = phase_q & busy;
  assign c_accumulate    = (state_q == S_ACCU);
  assign c_synapse_index = syn_q;
  assign network_time    = time_q;
  assign fifo_level      = count_q;
  assign done            = done_q;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// tb/tb_snn_step_scheduler.sv - self-checking bench for snn_step_scheduler
module tb_snn_step_scheduler;
  localparam int ND   = 4;
  localparam int SRD  = 16384;
  localparam int NI   = 4;
  localparam int FD   = 8;
  localparam int MAXT = 12;
  localparam int NW   = $clog2(ND);
  localparam int SW   = $clog2(SRD);
  localparam int TW   = $clog2(MAXT);
  localparam int LW   = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [TW-1:0] num_steps = '0;
  logic [NW-1:0] c_neuron_index;
  logic [SW-1:0] c_synapse_index;
  logic          c_neuron_we, c_accumulate, busy, done;
  logic [TW-1:0] network_time;
  logic [LW-1:0] fifo_level;

  snn_step_scheduler_if #(.N_IN(NI), .SW(SW)) spk ();

  snn_step_scheduler #(
    .NR_DEPTH(ND), .SR_DEPTH(SRD), .N_IN(NI), .FIFO_DEPTH(FD), .MAX_NETWORK_TIME(MAXT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .num_steps(num_steps),
    .spk(spk.slave),
    .c_neuron_index(c_neuron_index), .c_synapse_index(c_synapse_index),
    .c_neuron_we(c_neuron_we), .c_accumulate(c_accumulate),
    .network_time(network_time), .fifo_level(fifo_level),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Behavioural model: a run is a sequence of 2*ND-cycle sweeps, position m_t
  // within the current sweep; the spike FIFO is a plain queue.
  bit m_busy, m_accu, m_done, m_stopf;
  int m_t, m_time, m_target, m_rr, m_syn;
  int q[$];

  task m_reset();
    m_busy = 0; m_accu = 0; m_done = 0; m_stopf = 0;
    m_t = 0; m_time = 0; m_target = 0; m_rr = 0; m_syn = 0;
    q.delete();
  endtask

  function automatic int model_ready();
    if (q.size() >= FD) return 0;
    for (int off = 0; off < NI; off++) begin
      int ch = (m_rr + off) % NI;
      if (spk.in_valid[ch]) return 1 << ch;
    end
    return 0;
  endfunction

  task m_step(input int grant);
    int k;
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_accu = 0; m_t = 0; m_target = int'(num_steps); m_stopf = 0;
      end
    end else begin
      if (stop) m_stopf = 1;
      if (m_t < 2*ND - 1) m_t++;
      else begin
        m_t = 0;
        if (q.size() > 0) begin
          m_syn = q.pop_front();
          m_accu = 1;
        end else begin
          m_accu = 0;
          m_time = (m_time + 1) % MAXT;
          if (m_stopf || (m_target != 0 && m_time == m_target)) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
    if (grant != 0) begin
      k = $clog2(grant);
      q.push_back(int'(spk.in_index[k*SW +: SW]));
      m_rr = (k + 1) % NI;
    end
  endtask

  always @(negedge clk) begin
    int g;
    if (reset) m_reset();
    g = model_ready();
    chk("in_ready", int'(spk.in_ready), g);
    chk("neuron_index", int'(c_neuron_index), m_busy ? m_t / 2 : 0);
    chk("neuron_we", int'(c_neuron_we), (m_busy && (m_t % 2 == 1)) ? 1 : 0);
    chk("accumulate", int'(c_accumulate), (m_busy && m_accu) ? 1 : 0);
    chk("synapse_index", int'(c_synapse_index), m_syn);
    chk("network_time", int'(network_time), m_time);
    chk("fifo_level", int'(fifo_level), q.size());
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    if (!reset) m_step(g);
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task ticks(input int n);
    repeat (n) tick();
  endtask

  task do_reset();
    tick();
    start = 0; stop = 0; spk.in_valid = '0;
    reset = 1;
    ticks(2);
    reset = 0;
  endtask

  initial begin
    spk.in_valid = '0;
    spk.in_index = '0;
    ticks(3);
    reset = 0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_level", int'(fifo_level), 0);

    // two steps, no spikes
    tick(); start = 1; num_steps = 2;
    tick(); start = 0;
    chk("t1_c1_idx", int'(c_neuron_index), 0); chk("t1_c1_we", int'(c_neuron_we), 0);
    chk("t1_c1_busy", int'(busy), 1);
    tick(); chk("t1_c2_idx", int'(c_neuron_index), 0); chk("t1_c2_we", int'(c_neuron_we), 1);
    tick(); chk("t1_c3_idx", int'(c_neuron_index), 1); chk("t1_c3_we", int'(c_neuron_we), 0);
    ticks(13); chk("t1_c16_idx", int'(c_neuron_index), 3); chk("t1_c16_done", int'(done), 0);
    tick(); chk("t1_c17_done", int'(done), 1); chk("t1_c17_time", int'(network_time), 2);
    chk("t1_c17_busy", int'(busy), 0);
    tick(); chk("t1_c18_done", int'(done), 0);

    // one spike on ch2 during the step
    tick(); start = 1; num_steps = 3;
    tick(); start = 0;
    tick(); spk.in_valid = 4'b0100; spk.in_index[2*SW +: SW] = 14'h155; #1;
    chk("t2_ready", int'(spk.in_ready), 4);
    tick(); spk.in_valid = '0; chk("t2_level", int'(fifo_level), 1);
    ticks(5); chk("t2_c8_accu", int'(c_accumulate), 0);
    tick(); chk("t2_c9_accu", int'(c_accumulate), 1); chk("t2_c9_syn", int'(c_synapse_index), 'h155);
    chk("t2_c9_level", int'(fifo_level), 0);
    ticks(7); chk("t2_c16_accu", int'(c_accumulate), 1); chk("t2_c16_we", int'(c_neuron_we), 1);
    tick(); chk("t2_c17_done", int'(done), 1); chk("t2_c17_time", int'(network_time), 3);

    // all channels valid from rr=0
    do_reset();
    tick(); spk.in_valid = 4'b1111;
    for (int k = 0; k < NI; k++) spk.in_index[k*SW +: SW] = SW'(16 + k);
    #1; chk("t3_ready0", int'(spk.in_ready), 1);
    tick(); #1; chk("t3_ready1", int'(spk.in_ready), 2);
    tick(); #1; chk("t3_ready2", int'(spk.in_ready), 4);
    tick(); #1; chk("t3_ready3", int'(spk.in_ready), 8);
    tick(); spk.in_valid = '0; chk("t3_level", int'(fifo_level), 4);
    tick(); start = 1; num_steps = 1;
    tick(); start = 0;
    ticks(8); chk("t3_r9_syn", int'(c_synapse_index), 'h10);
    ticks(8); chk("t3_r17_syn", int'(c_synapse_index), 'h11);
    ticks(23); chk("t3_r40_done", int'(done), 0);
    tick(); chk("t3_r41_done", int'(done), 1); chk("t3_r41_syn", int'(c_synapse_index), 'h13);

    // FIFO full boundary
    do_reset();
    tick(); spk.in_valid = 4'b0001; spk.in_index[0 +: SW] = 14'h2A; #1;
    chk("t4_ready0", int'(spk.in_ready), 1);
    ticks(8); #1; chk("t4_full_ready", int'(spk.in_ready), 0); chk("t4_full_level", int'(fifo_level), 8);
    tick(); start = 1; num_steps = 1;
    tick(); start = 0;
    ticks(7); chk("t4_r8_ready", int'(spk.in_ready), 0);
    tick(); chk("t4_r9_ready", int'(spk.in_ready), 1); chk("t4_r9_level", int'(fifo_level), 7);
    tick(); spk.in_valid = '0; chk("t4_r10_level", int'(fifo_level), 8);
    ticks(70); chk("t4_r80_busy", int'(busy), 1);
    tick(); chk("t4_r81_done", int'(done), 1); chk("t4_r81_level", int'(fifo_level), 0);

    // free-run with stop
    tick(); start = 1; num_steps = 0;
    tick(); start = 0;
    ticks(4); stop = 1;
    tick(); stop = 0;
    ticks(2); chk("t5_r8_busy", int'(busy), 1);
    tick(); chk("t5_r9_done", int'(done), 1); chk("t5_r9_time", int'(network_time), 2);
    chk("t5_r9_busy", int'(busy), 0);

    // reset mid-ACCU
    tick(); start = 1; num_steps = 0;
    tick(); start = 0;
    tick(); spk.in_valid = 4'b0010; spk.in_index[SW +: SW] = 14'h7;
    tick(); spk.in_valid = '0;
    ticks(8); chk("t6_accu", int'(c_accumulate), 1);
    reset = 1; #1;
    chk("t6_rst_accu", int'(c_accumulate), 0); chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_level", int'(fifo_level), 0); chk("t6_rst_syn", int'(c_synapse_index), 0);
    tick(); reset = 0;
    tick(); start = 1; num_steps = 1;
    tick(); start = 0; chk("t6_restart_busy", int'(busy), 1);
    ticks(8); chk("t6_done", int'(done), 1); chk("t6_time", int'(network_time), 1);

    // network_time wrap
    do_reset();
    tick(); start = 1; num_steps = 5;
    tick(); start = 0;
    ticks(40); chk("wrap_a_done", int'(done), 1); chk("wrap_a_time", int'(network_time), 5);
    tick(); start = 1; num_steps = 3;
    tick(); start = 0;
    ticks(80); chk("wrap_b_done", int'(done), 1); chk("wrap_b_time", int'(network_time), 3);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      spk.in_valid = ($urandom_range(0, 5) == 0) ? NI'($urandom) : '0;
      for (int k = 0; k < NI; k++) spk.in_index[k*SW +: SW] = SW'($urandom);
      start = ($urandom_range(0, 15) == 0);
      stop = ($urandom_range(0, 59) == 0);
      num_steps = TW'($urandom_range(0, 3));
      reset = (c == 1500);
    end
    tick();
    spk.in_valid = '0; start = 0; stop = 0; reset = 0;
    ticks(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
